// File: rtl/fpu_pkg.sv
// fpu_pkg: shared FPU operand classes, standard format widths and shift-width helper.
`default_nettype none

package fpu_pkg;

  typedef enum logic [2:0] {
    ZERO      = 3'd0,
    SUBNORMAL = 3'd1,
    NORMAL    = 3'd2,
    INF       = 3'd3,
    QNAN      = 3'd4,
    SNAN      = 3'd5
  } fp_class_e;

  localparam int unsigned HALF_EXP_W   = 5;
  localparam int unsigned HALF_FRAC_W  = 10;
  localparam int unsigned SINGLE_EXP_W  = 8;
  localparam int unsigned SINGLE_FRAC_W = 23;
  localparam int unsigned DOUBLE_EXP_W  = 11;
  localparam int unsigned DOUBLE_FRAC_W = 52;

  // Shift range covers the hidden bit plus guard/round/sticky positions.
  function automatic int unsigned shift_width(input int unsigned frac_w);
    return $clog2(frac_w + 4);
  endfunction

endpackage

`default_nettype wire

// File: rtl/fp_classify.sv
// fp_classify: combinational class / effective exponent / mantissa decode of one operand.
// Optional FPU_DAZ_EN flushes subnormals to ZERO.
`default_nettype none

module fp_classify
  import fpu_pkg::*;
#(
  parameter int unsigned EXP_W  = 8,
  parameter int unsigned FRAC_W = 23
) (
  input  logic [EXP_W-1:0]  exp,
  input  logic [FRAC_W-1:0] frac,
  output fp_class_e         cls,
  output logic [EXP_W-1:0]  eff_exp,
  output logic [FRAC_W:0]   mant
);

  logic exp_zero;
  logic exp_ones;
  logic frac_zero;

  assign exp_zero  = (exp == '0);
  assign exp_ones  = &exp;
  assign frac_zero = (frac == '0);

  always_comb begin
    cls     = NORMAL;
    eff_exp = exp;
    mant    = {1'b1, frac};
    if (exp_zero) begin
      // Subnormals share the exponent of the smallest normal.
      eff_exp = {{(EXP_W-1){1'b0}}, 1'b1};
      mant    = {1'b0, frac};
      cls     = frac_zero ? ZERO : SUBNORMAL;
`ifdef FPU_DAZ_EN
      cls     = ZERO;
      mant    = '0;
`endif
    end else if (exp_ones) begin
      if (frac_zero)
        cls = INF;
      else if (frac[FRAC_W-1])
        cls = QNAN;
      else
        cls = SNAN;
    end
  end

endmodule

`default_nettype wire

// File: rtl/fp_operand_align_pipe.sv
// fp_operand_align_pipe: two-stage decode/align of an FP operand pair with valid/ready back-pressure.
// Optional FPU_DAZ_EN (denormals-are-zero) is handled inside fp_classify.
`default_nettype none

module fp_operand_align_pipe
  import fpu_pkg::*;
#(
  parameter int unsigned EXP_W  = 8,
  parameter int unsigned FRAC_W = 23,
  parameter int unsigned TAG_W  = 4
) (
  input  logic                             clk_i,
  input  logic                             rst_n_i,
  input  logic                             in_valid_i,
  output logic                             in_ready_o,
  input  logic [EXP_W+FRAC_W:0]            x_i,
  input  logic [EXP_W+FRAC_W:0]            y_i,
  input  logic [TAG_W-1:0]                 tag_i,
  output logic                             out_valid_o,
  input  logic                             out_ready_i,
  output logic                             big_sign_o,
  output logic                             small_sign_o,
  output logic [EXP_W-1:0]                 big_exp_o,
  output logic [EXP_W-1:0]                 small_exp_o,
  output logic [FRAC_W:0]                  big_mant_o,
  output logic [FRAC_W:0]                  small_mant_o,
  output logic                             swapped_o,
  output logic [EXP_W-1:0]                 exp_diff_o,
  output logic [shift_width(FRAC_W)-1:0]   shift_o,
  output logic [2:0]                       x_class_o,
  output logic [2:0]                       y_class_o,
  output logic [TAG_W-1:0]                 tag_o
);

  localparam int unsigned SHIFT_W   = shift_width(FRAC_W);
  localparam int unsigned SHIFT_SAT = FRAC_W + 3;

  // Stage 1 decode
  fp_class_e               x_cls_d, y_cls_d;
  logic [EXP_W-1:0]        x_exp_d, y_exp_d;
  logic [FRAC_W:0]         x_mant_d, y_mant_d;

  fp_classify #(.EXP_W(EXP_W), .FRAC_W(FRAC_W)) u_cls_x (
    .exp     (x_i[EXP_W+FRAC_W-1:FRAC_W]),
    .frac    (x_i[FRAC_W-1:0]),
    .cls     (x_cls_d),
    .eff_exp (x_exp_d),
    .mant    (x_mant_d)
  );

  fp_classify #(.EXP_W(EXP_W), .FRAC_W(FRAC_W)) u_cls_y (
    .exp     (y_i[EXP_W+FRAC_W-1:FRAC_W]),
    .frac    (y_i[FRAC_W-1:0]),
    .cls     (y_cls_d),
    .eff_exp (y_exp_d),
    .mant    (y_mant_d)
  );

  logic                    s1_valid, s2_valid;
  logic                    s1_ready, s2_ready;
  logic                    s1_x_sign, s1_y_sign;
  logic [EXP_W-1:0]        s1_x_exp, s1_y_exp;
  logic [FRAC_W:0]         s1_x_mant, s1_y_mant;
  fp_class_e               s1_x_cls, s1_y_cls;
  logic [TAG_W-1:0]        s1_tag;

  assign s2_ready   = !s2_valid || out_ready_i;
  assign s1_ready   = !s1_valid || s2_ready;
  assign in_ready_o = s1_ready;
  assign out_valid_o = s2_valid;

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      s1_valid  <= 1'b0;
      s1_x_sign <= 1'b0;
      s1_y_sign <= 1'b0;
      s1_x_exp  <= '0;
      s1_y_exp  <= '0;
      s1_x_mant <= '0;
      s1_y_mant <= '0;
      s1_x_cls  <= ZERO;
      s1_y_cls  <= ZERO;
      s1_tag    <= '0;
    end else if (s1_ready) begin
      s1_valid <= in_valid_i;
      if (in_valid_i) begin
        s1_x_sign <= x_i[EXP_W+FRAC_W];
        s1_y_sign <= y_i[EXP_W+FRAC_W];
        s1_x_exp  <= x_exp_d;
        s1_y_exp  <= y_exp_d;
        s1_x_mant <= x_mant_d;
        s1_y_mant <= y_mant_d;
        s1_x_cls  <= x_cls_d;
        s1_y_cls  <= y_cls_d;
        s1_tag    <= tag_i;
      end
    end
  end

  // Stage 2 align: magnitude order on {eff_exp, mant}, ties keep X as big.
  logic                    y_big;
  logic [EXP_W-1:0]        big_exp_d, small_exp_d, diff_d;
  logic [31:0]             diff_ext;
  logic [SHIFT_W-1:0]      shift_d;

  assign y_big       = {s1_y_exp, s1_y_mant} > {s1_x_exp, s1_x_mant};
  assign big_exp_d   = y_big ? s1_y_exp : s1_x_exp;
  assign small_exp_d = y_big ? s1_x_exp : s1_y_exp;
  assign diff_d      = big_exp_d - small_exp_d;
  assign diff_ext    = 32'(diff_d);
  assign shift_d     = (diff_ext > 32'(SHIFT_SAT)) ? SHIFT_W'(SHIFT_SAT) : SHIFT_W'(diff_d);

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      s2_valid     <= 1'b0;
      big_sign_o   <= 1'b0;
      small_sign_o <= 1'b0;
      big_exp_o    <= '0;
      small_exp_o  <= '0;
      big_mant_o   <= '0;
      small_mant_o <= '0;
      swapped_o    <= 1'b0;
      exp_diff_o   <= '0;
      shift_o      <= '0;
      x_class_o    <= 3'(ZERO);
      y_class_o    <= 3'(ZERO);
      tag_o        <= '0;
    end else if (s2_ready) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        big_sign_o   <= y_big ? s1_y_sign : s1_x_sign;
        small_sign_o <= y_big ? s1_x_sign : s1_y_sign;
        big_exp_o    <= big_exp_d;
        small_exp_o  <= small_exp_d;
        big_mant_o   <= y_big ? s1_y_mant : s1_x_mant;
        small_mant_o <= y_big ? s1_x_mant : s1_y_mant;
        swapped_o    <= y_big;
        exp_diff_o   <= diff_d;
        shift_o      <= shift_d;
        x_class_o    <= 3'(s1_x_cls);
        y_class_o    <= 3'(s1_y_cls);
        tag_o        <= s1_tag;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_fp_operand_align_pipe.sv
// tb_fp_operand_align_pipe: directed + randomized scoreboard bench for single-precision configuration.
`default_nettype none

module tb_fp_operand_align_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready;
  logic [31:0] x, y;
  logic [3:0]  tag;
  logic        out_valid, out_ready;
  logic        big_sign, small_sign, swapped;
  logic [7:0]  big_exp, small_exp, exp_diff;
  logic [23:0] big_mant, small_mant;
  logic [4:0]  shift;
  logic [2:0]  x_class, y_class;
  logic [3:0]  tag_out;

  always #5 clk = ~clk;

  fp_operand_align_pipe #(.EXP_W(8), .FRAC_W(23), .TAG_W(4)) dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .in_valid_i(in_valid), .in_ready_o(in_ready),
    .x_i(x), .y_i(y), .tag_i(tag),
    .out_valid_o(out_valid), .out_ready_i(out_ready),
    .big_sign_o(big_sign), .small_sign_o(small_sign),
    .big_exp_o(big_exp), .small_exp_o(small_exp),
    .big_mant_o(big_mant), .small_mant_o(small_mant),
    .swapped_o(swapped), .exp_diff_o(exp_diff), .shift_o(shift),
    .x_class_o(x_class), .y_class_o(y_class), .tag_o(tag_out)
  );

  typedef struct packed {
    logic       bs, ss;
    logic [7:0] be, se;
    logic [23:0] bm, sm;
    logic       sw;
    logic [7:0] ed;
    logic [4:0] sh;
    logic [2:0] xc, yc;
    logic [3:0] tg;
  } res_t;

  int   checks = 0;
  int   errors = 0;
  res_t sb[$];
  res_t held;
  logic hold_v = 1'b0;
  logic rand_rdy = 1'b0;
  logic [31:0] last_op = 32'h3F800000;

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, want);
    end
  endtask

  // Reference decode straight from the IEEE-754 field rules.
  function automatic void decode(input logic [31:0] op, output logic [2:0] c,
                                 output int unsigned ee, output int unsigned m);
    int unsigned e, f;
    e = int'(op[30:23]);
    f = int'(op[22:0]);
    if (e == 0) begin
      ee = 1;
      m  = f;
      c  = (f == 0) ? 3'd0 : 3'd1;
`ifdef FPU_DAZ_EN
      c = 3'd0;
      m = 0;
`endif
    end else begin
      ee = e;
      m  = f + (1 << 23);
      if (e == 255) c = (f == 0) ? 3'd3 : (op[22] ? 3'd4 : 3'd5);
      else          c = 3'd2;
    end
  endfunction

  function automatic res_t model(input logic [31:0] a, input logic [31:0] b, input logic [3:0] t);
    res_t r;
    logic [2:0] ca, cb;
    int unsigned ea, eb, ma, mb, d;
    longint unsigned ka, kb;
    decode(a, ca, ea, ma);
    decode(b, cb, eb, mb);
    ka = longint'(ea) * 64'd16777216 + longint'(ma);
    kb = longint'(eb) * 64'd16777216 + longint'(mb);
    r.sw = (kb > ka);
    r.bs = r.sw ? b[31] : a[31];
    r.ss = r.sw ? a[31] : b[31];
    r.be = 8'(r.sw ? eb : ea);
    r.se = 8'(r.sw ? ea : eb);
    r.bm = 24'(r.sw ? mb : ma);
    r.sm = 24'(r.sw ? ma : mb);
    d    = r.sw ? eb - ea : ea - eb;
    r.ed = 8'(d);
    r.sh = 5'((d > 26) ? 26 : d);
    r.xc = ca;
    r.yc = cb;
    r.tg = t;
    return r;
  endfunction

  function automatic res_t observed();
    return {big_sign, small_sign, big_exp, small_exp, big_mant, small_mant,
            swapped, exp_diff, shift, x_class, y_class, tag_out};
  endfunction

  // Scoreboard monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      sb.delete();
      hold_v = 1'b0;
    end else begin
      if (out_valid) begin
        if (hold_v) check("hold_stable", observed(), held);
        if (out_ready) begin
          check("sb_nonempty", 128'(sb.size() != 0), 128'd1);
          if (sb.size() != 0) check("result", observed(), sb.pop_front());
          hold_v = 1'b0;
        end else begin
          hold_v = 1'b1;
          held   = observed();
        end
      end else begin
        hold_v = 1'b0;
      end
      if (in_valid && in_ready) sb.push_back(model(x, y, tag));
    end
  end

  always @(posedge clk) begin
    if (rand_rdy) begin
      #1;
      out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [3:0] t);
    logic acc;
    acc = 1'b0;
    x = a; y = b; tag = t; in_valid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      if (acc) break;
    end
    check("accept_timeout", 128'(acc), 128'd1);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 200; i++) begin
      if (sb.size() == 0 && !out_valid) break;
      @(posedge clk);
      #1;
    end
    check("drain_empty", 128'(sb.size()), 128'd0);
  endtask

  // Send one pair with out_ready=1 and return once it sits on the outputs.
  task automatic send_and_see(input logic [31:0] a, input logic [31:0] b, input logic [3:0] t);
    out_ready = 1'b1;
    send(a, b, t);
    @(posedge clk);
    #1;
    check("latency_valid", 128'(out_valid), 128'd1);
  endtask

  function automatic logic [31:0] gen();
    logic [31:0] v;
    case ($urandom_range(0, 7))
      0:       v = $urandom;
      1:       v = {1'($urandom), 8'h00, 23'($urandom_range(0, 3) == 0 ? 0 : $urandom)};
      2:       v = {1'($urandom), 8'hFF, 23'($urandom_range(0, 2) == 0 ? 0 : $urandom)};
      3:       v = {1'($urandom), 31'h0};
      4, 5, 6: v = {1'($urandom), 8'(8'h70 + $urandom_range(0, 40)), 23'($urandom)};
      default: v = {~last_op[31], last_op[30:0]};
    endcase
    last_op = v;
    return v;
  endfunction

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    x = '0; y = '0; tag = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_out_valid", 128'(out_valid), 128'd0);
    check("reset_outputs", observed(), '0);
    check("reset_in_ready", 128'(in_ready), 128'd1);
    rst_n = 1'b1;

    send_and_see(32'h40400000, 32'h3F800000, 4'd1);
    check("ord_big_exp", 128'(big_exp), 128'h80);
    check("ord_big_mant", 128'(big_mant), 128'hC00000);
    check("ord_small_exp", 128'(small_exp), 128'h7F);
    check("ord_small_mant", 128'(small_mant), 128'h800000);
    check("ord_swapped", 128'(swapped), 128'd0);
    check("ord_exp_diff", 128'(exp_diff), 128'd1);
    check("ord_shift", 128'(shift), 128'd1);
    check("ord_classes", 128'({x_class, y_class}), 128'({3'd2, 3'd2}));
    check("ord_tag", 128'(tag_out), 128'd1);

    send_and_see(32'h3F800000, 32'hC0400000, 4'd2);
    check("swap_swapped", 128'(swapped), 128'd1);
    check("swap_signs", 128'({big_sign, small_sign}), 128'({1'b1, 1'b0}));
    check("swap_exp_diff", 128'(exp_diff), 128'd1);

    send_and_see(32'h3F800000, 32'hBF800000, 4'd3);
    check("tie_swapped", 128'(swapped), 128'd0);
    check("tie_exp_diff", 128'(exp_diff), 128'd0);

    send_and_see(32'h7F800000, 32'h7FC00000, 4'd4);
    check("inf_qnan_class", 128'({x_class, y_class}), 128'({3'd3, 3'd4}));
    send_and_see(32'h7F800001, 32'h3F800000, 4'd5);
    check("snan_class", 128'(x_class), 128'd5);

    send_and_see(32'h7F000000, 32'h3F800000, 4'd6);
    check("sat_exp_diff", 128'(exp_diff), 128'h7F);
    check("sat_shift", 128'(shift), 128'd26);

    send_and_see(32'h00000001, 32'h00000000, 4'd7);
`ifdef FPU_DAZ_EN
    check("daz_classes", 128'({x_class, y_class}), 128'({3'd0, 3'd0}));
    check("daz_mants", 128'({big_mant, small_mant}), 128'd0);
`else
    check("sub_classes", 128'({x_class, y_class}), 128'({3'd1, 3'd0}));
    check("sub_big_mant", 128'(big_mant), 128'd1);
    check("sub_big_exp", 128'(big_exp), 128'd1);
`endif
    check("sub_swapped", 128'(swapped), 128'd0);
    drain();

    // Back-pressure: two pairs fill the pipe, the third must wait.
    out_ready = 1'b0;
    send(32'h3F800000, 32'h40000000, 4'd1);
    send(32'h40000000, 32'h3F800000, 4'd2);
    x = 32'h40800000; y = 32'h3F800000; tag = 4'd3; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_in_ready_low", 128'(in_ready), 128'd0);
      check("bp_tag_hold", 128'(tag_out), 128'd1);
      check("bp_out_valid", 128'(out_valid), 128'd1);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    send(32'h40800000, 32'h3F800000, 4'd3);
    drain();

    // Reset with two pairs in flight.
    out_ready = 1'b0;
    send(32'h40400000, 32'h3F800000, 4'd9);
    send(32'h3F800000, 32'h40400000, 4'd10);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("rst_mid_valid", 128'(out_valid), 128'd0);
    check("rst_mid_outputs", observed(), '0);
    @(negedge clk);
    check("rst_mid_in_ready", 128'(in_ready), 128'd1);
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("rst_no_stale", 128'(out_valid), 128'd0);
    end

    // Randomized traffic with random back-pressure.
    @(posedge clk);
    #1;
    rand_rdy = 1'b1;
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
      end else begin
        send(gen(), gen(), 4'($urandom));
      end
    end
    rand_rdy = 1'b0;
    @(posedge clk);
    #2;
    out_ready = 1'b1;
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
